// File: rtl/flit_receiver_if.sv
// Flit link and mapper-side pop interface for flit_receiver.
// The slave modport is the receiver; the master modport is the link/mapper side.
interface flit_receiver_if #(
   parameter int DATA_WIDTH = 32,
   parameter int TAG_WIDTH  = 4
);
   logic                            enablein;
   logic [DATA_WIDTH+TAG_WIDTH-1:0] datain;
   logic                            restart;
   logic                            ren;
   logic [DATA_WIDTH-1:0]           dataout;
   logic                            dataout_valid;
   logic [DATA_WIDTH-1:0]           keywordnumber;
   logic [DATA_WIDTH-1:0]           textfilenumber;
   logic [15:0]                     word_count;
   logic [15:0]                     seq_count;
   logic                            full;
   logic                            empty;
   logic                            overflow;
   logic                            done;

   modport master (
      output enablein, datain, restart, ren,
      input  dataout, dataout_valid, keywordnumber, textfilenumber,
             word_count, seq_count, full, empty, overflow, done
   );

   modport slave (
      input  enablein, datain, restart, ren,
      output dataout, dataout_valid, keywordnumber, textfilenumber,
             word_count, seq_count, full, empty, overflow, done
   );
endinterface

// File: rtl/flit_receiver.sv
// Receiving end of the scheduler flit link: decodes route tags, captures the two
// header words and buffers payload words in a FIFO popped by the local mapper.
module flit_receiver #(
   parameter int              DATA_WIDTH = 32,
   parameter int              TAG_WIDTH  = 4,
   parameter int              FLIT_WIDTH = 36,
   parameter logic [3:0]      MY_TAG     = 4'b1001,
   parameter logic [3:0]      SEQ_TAG    = 4'b0001,
   parameter int              FIFO_DEPTH = 16,
   parameter int              PTR_WIDTH  = 4
) (
   input logic           clk,
   input logic           reset,
   flit_receiver_if.slave bus
);
   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_HDR_TF  = 2'd1,
      S_PAYLOAD = 2'd2,
      S_DONE    = 2'd3
   } state_e;

   localparam logic [DATA_WIDTH-1:0] TERM_WORD  = {DATA_WIDTH{1'b1}};
   localparam logic [PTR_WIDTH:0]    COUNT_FULL = (PTR_WIDTH+1)'(FIFO_DEPTH);

   state_e                  state_q, state_d;
   logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
   logic [PTR_WIDTH-1:0]    wr_ptr_q, rd_ptr_q;
   logic [PTR_WIDTH:0]      count_q, count_d;
   logic [DATA_WIDTH-1:0]   kw_q, kw_d, tf_q, tf_d, dout_q, dout_d;
   logic [15:0]             wc_q, wc_d, sc_q, sc_d;
   logic                    dv_q, ovf_q, ovf_d;

   logic [DATA_WIDTH-1:0]   word_s;
   logic [TAG_WIDTH-1:0]    tag_s;
   logic                    my_s, seq_s, term_s, full_s, empty_s;
   logic                    push_req_s, push_s, pop_s;

   assign word_s  = bus.datain[FLIT_WIDTH-1:TAG_WIDTH];
   assign tag_s   = bus.datain[TAG_WIDTH-1:0];
   assign my_s    = bus.enablein && (tag_s == MY_TAG);
   assign seq_s   = bus.enablein && (tag_s == SEQ_TAG);
   assign term_s  = (word_s == TERM_WORD);
   assign full_s  = (count_q == COUNT_FULL);
   assign empty_s = (count_q == (PTR_WIDTH+1)'(0));

   // Header/payload sequencing; terminator ends the stream from any live state.
   always_comb begin
      state_d    = state_q;
      kw_d       = kw_q;
      tf_d       = tf_q;
      push_req_s = 1'b0;
      if (my_s) begin
         case (state_q)
            S_IDLE: begin
               if (term_s) begin
                  state_d = S_DONE;
               end else begin
                  kw_d    = word_s;
                  state_d = S_HDR_TF;
               end
            end
            S_HDR_TF: begin
               if (term_s) begin
                  state_d = S_DONE;
               end else begin
                  tf_d    = word_s;
                  state_d = S_PAYLOAD;
               end
            end
            S_PAYLOAD: begin
               if (term_s) begin
                  state_d = S_DONE;
               end else begin
                  push_req_s = 1'b1;
               end
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // Push/pop arbitration; a push into a full FIFO is dropped even alongside a pop.
   always_comb begin
      push_s = push_req_s && !full_s && !bus.restart;
      pop_s  = bus.ren && !empty_s;
      ovf_d  = ovf_q || (push_req_s && full_s);
      dout_d = pop_s ? mem_q[rd_ptr_q] : dout_q;
      wc_d   = (push_s && (wc_q != 16'hFFFF)) ? (wc_q + 16'd1) : wc_q;
      sc_d   = (seq_s && (sc_q != 16'hFFFF)) ? (sc_q + 16'd1) : sc_q;
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + (PTR_WIDTH+1)'(1);
         2'b01:   count_d = count_q - (PTR_WIDTH+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // State, pointers, counters and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         kw_q     <= '0;
         tf_q     <= '0;
         dout_q   <= '0;
         dv_q     <= 1'b0;
         ovf_q    <= 1'b0;
         wc_q     <= 16'd0;
         sc_q     <= 16'd0;
      end else if (bus.restart) begin
         state_q  <= S_IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         kw_q     <= '0;
         tf_q     <= '0;
         dout_q   <= '0;
         dv_q     <= 1'b0;
         ovf_q    <= 1'b0;
         wc_q     <= 16'd0;
         sc_q     <= 16'd0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= push_s ? (wr_ptr_q + PTR_WIDTH'(1)) : wr_ptr_q;
         rd_ptr_q <= pop_s ? (rd_ptr_q + PTR_WIDTH'(1)) : rd_ptr_q;
         count_q  <= count_d;
         kw_q     <= kw_d;
         tf_q     <= tf_d;
         dout_q   <= dout_d;
         dv_q     <= pop_s;
         ovf_q    <= ovf_d;
         wc_q     <= wc_d;
         sc_q     <= sc_d;
      end
   end

   // Payload storage; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_q[wr_ptr_q] <= word_s;
      end
   end

   assign bus.dataout        = dout_q;
   assign bus.dataout_valid  = dv_q;
   assign bus.keywordnumber  = kw_q;
   assign bus.textfilenumber = tf_q;
   assign bus.word_count     = wc_q;
   assign bus.seq_count      = sc_q;
   assign bus.full           = full_s;
   assign bus.empty          = empty_s;
   assign bus.overflow       = ovf_q;
   assign bus.done           = (state_q == S_DONE);
endmodule

// File: tb/tb_flit_receiver.sv
// Self-checking bench for flit_receiver: vector table, directed corner sequences
// and randomized traffic checked against a queue-based reference model.
module tb_flit_receiver;
   localparam logic [3:0]  MY  = 4'b1001;
   localparam logic [3:0]  SEQ = 4'b0001;
   localparam logic [3:0]  OTH = 4'b0010;
   localparam logic [31:0] TERM = 32'hFFFF_FFFF;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   flit_receiver_if bus ();
   flit_receiver dut (.clk(clk), .reset(reset), .bus(bus));

   int n_chk = 0;
   int n_fail = 0;

   // reference model: header count, done flag and a plain word queue
   int          m_hdr;
   bit          m_done, m_ovf, m_dv;
   logic [31:0] m_kw, m_tf, m_dout;
   logic [15:0] m_wc, m_sc;
   logic [31:0] m_q[$];

   typedef struct {
      logic        en;
      logic [3:0]  tag;
      logic [31:0] data;
      logic        rn;
      logic [31:0] kw;
      logic [31:0] tf;
      logic [15:0] wc;
      logic        dn;
      logic        dv;
      logic [31:0] dout;
      logic        emp;
   } vec_t;
   vec_t tbl[10];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      m_hdr = 0; m_done = 0; m_ovf = 0; m_dv = 0;
      m_kw = 32'd0; m_tf = 32'd0; m_dout = 32'd0;
      m_wc = 16'd0; m_sc = 16'd0;
      m_q.delete();
   endtask

   task automatic model_update(input logic en, input logic [3:0] tag, input logic [31:0] data,
                               input logic rn, input logic rs);
      int          sz;
      bit          pop, push;
      logic [31:0] head;
      if (rs) begin
         model_clear();
      end else begin
         sz   = m_q.size();
         pop  = rn && (sz > 0);
         push = 0;
         head = pop ? m_q[0] : 32'd0;
         if (en && tag == MY && !m_done) begin
            if (data == TERM) m_done = 1;
            else if (m_hdr == 0) begin m_kw = data; m_hdr = 1; end
            else if (m_hdr == 1) begin m_tf = data; m_hdr = 2; end
            else if (sz < 16) begin
               push = 1;
               if (m_wc != 16'hFFFF) m_wc = m_wc + 16'd1;
            end else m_ovf = 1;
         end
         if (en && tag == SEQ && m_sc != 16'hFFFF) m_sc = m_sc + 16'd1;
         if (pop) begin
            void'(m_q.pop_front());
            m_dout = head;
         end
         m_dv = pop;
         if (push) m_q.push_back(data);
      end
   endtask

   task automatic compare_all();
      chk("dataout",        bus.dataout,               m_dout);
      chk("dataout_valid",  32'(bus.dataout_valid),    32'(m_dv));
      chk("keywordnumber",  bus.keywordnumber,         m_kw);
      chk("textfilenumber", bus.textfilenumber,        m_tf);
      chk("word_count",     32'(bus.word_count),       32'(m_wc));
      chk("seq_count",      32'(bus.seq_count),        32'(m_sc));
      chk("full",           32'(bus.full),             32'(m_q.size() == 16));
      chk("empty",          32'(bus.empty),            32'(m_q.size() == 0));
      chk("overflow",       32'(bus.overflow),         32'(m_ovf));
      chk("done",           32'(bus.done),             32'(m_done));
   endtask

   task automatic step(input logic en, input logic [3:0] tag, input logic [31:0] data,
                       input logic rn, input logic rs);
      bus.enablein = en;
      bus.datain   = {data, tag};
      bus.ren      = rn;
      bus.restart  = rs;
      model_update(en, tag, data, rn, rs);
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic idle_step(input logic rn);
      step(1'b0, 4'h0, 32'd0, rn, 1'b0);
   endtask

   task automatic send(input logic [3:0] tag, input logic [31:0] data);
      step(1'b1, tag, data, 1'b0, 1'b0);
   endtask

   task automatic do_restart();
      step(1'b0, 4'h0, 32'd0, 1'b0, 1'b1);
   endtask

   task automatic async_reset();
      bus.enablein = 1'b0;
      bus.ren      = 1'b0;
      bus.restart  = 1'b0;
      reset = 1'b1;
      model_clear();
      #2;
      compare_all();
      @(posedge clk);
      #1;
      reset = 1'b0;
      compare_all();
   endtask

   task automatic stream2();
      send(MY, 32'h3); send(MY, 32'h5);
      send(MY, 32'hA1); send(MY, 32'hA2); send(MY, 32'hA3);
      send(MY, TERM);
      for (int i = 0; i < 3; i++) idle_step(1'b1);
      idle_step(1'b0);
   endtask

   initial begin
      tbl[0] = '{1'b1, MY,   32'h3,  1'b0, 32'h3, 32'h0, 16'd0, 1'b0, 1'b0, 32'h0,  1'b1};
      tbl[1] = '{1'b1, MY,   32'h5,  1'b0, 32'h3, 32'h5, 16'd0, 1'b0, 1'b0, 32'h0,  1'b1};
      tbl[2] = '{1'b1, MY,   32'hA1, 1'b0, 32'h3, 32'h5, 16'd1, 1'b0, 1'b0, 32'h0,  1'b0};
      tbl[3] = '{1'b1, MY,   32'hA2, 1'b0, 32'h3, 32'h5, 16'd2, 1'b0, 1'b0, 32'h0,  1'b0};
      tbl[4] = '{1'b1, MY,   32'hA3, 1'b0, 32'h3, 32'h5, 16'd3, 1'b0, 1'b0, 32'h0,  1'b0};
      tbl[5] = '{1'b1, MY,   TERM,   1'b0, 32'h3, 32'h5, 16'd3, 1'b1, 1'b0, 32'h0,  1'b0};
      tbl[6] = '{1'b0, 4'h0, 32'h0,  1'b1, 32'h3, 32'h5, 16'd3, 1'b1, 1'b1, 32'hA1, 1'b0};
      tbl[7] = '{1'b0, 4'h0, 32'h0,  1'b1, 32'h3, 32'h5, 16'd3, 1'b1, 1'b1, 32'hA2, 1'b0};
      tbl[8] = '{1'b0, 4'h0, 32'h0,  1'b1, 32'h3, 32'h5, 16'd3, 1'b1, 1'b1, 32'hA3, 1'b1};
      tbl[9] = '{1'b0, 4'h0, 32'h0,  1'b0, 32'h3, 32'h5, 16'd3, 1'b1, 1'b0, 32'hA3, 1'b1};

      bus.enablein = 1'b0;
      bus.datain   = 36'd0;
      bus.ren      = 1'b0;
      bus.restart  = 1'b0;
      model_clear();
      @(posedge clk);
      #1;
      async_reset();

      // normal stream from the vector table
      for (int i = 0; i < 10; i++) begin
         step(tbl[i].en, tbl[i].tag, tbl[i].data, tbl[i].rn, 1'b0);
         chk($sformatf("tbl%0d_kw", i),    bus.keywordnumber,           tbl[i].kw);
         chk($sformatf("tbl%0d_tf", i),    bus.textfilenumber,          tbl[i].tf);
         chk($sformatf("tbl%0d_wc", i),    32'(bus.word_count),         32'(tbl[i].wc));
         chk($sformatf("tbl%0d_done", i),  32'(bus.done),               32'(tbl[i].dn));
         chk($sformatf("tbl%0d_dv", i),    32'(bus.dataout_valid),      32'(tbl[i].dv));
         chk($sformatf("tbl%0d_dout", i),  bus.dataout,                 tbl[i].dout);
         chk($sformatf("tbl%0d_empty", i), 32'(bus.empty),              32'(tbl[i].emp));
      end

      // reset mid-stream, then the next MY_TAG word is a fresh keyword
      do_restart();
      send(MY, 32'h11); send(MY, 32'h22); send(MY, 32'h33);
      async_reset();
      send(MY, 32'h77);
      chk("reset_next_kw", bus.keywordnumber, 32'h77);

      // tag filter: foreign and SEQ flits interleaved into stream 2
      do_restart();
      send(SEQ, 32'h1); send(MY, 32'h3); send(OTH, 32'hDEAD);
      send(MY, 32'h5); send(SEQ, 32'h2); send(MY, 32'hA1);
      send(OTH, TERM); send(MY, 32'hA2); send(SEQ, 32'h3);
      send(MY, 32'hA3); send(SEQ, TERM); send(MY, TERM);
      chk("filter_seq_count", 32'(bus.seq_count), 32'd4);
      chk("filter_word_count", 32'(bus.word_count), 32'd3);
      for (int i = 0; i < 3; i++) begin
         idle_step(1'b1);
         chk("filter_pop", bus.dataout, 32'hA1 + 32'(i));
      end

      // overflow: 18 payload words, no pops
      do_restart();
      send(MY, 32'h10); send(MY, 32'h20);
      for (int i = 1; i <= 18; i++) begin
         send(MY, 32'h100 + 32'(i));
         if (i == 15) chk("ovf_not_full_15", 32'(bus.full), 32'd0);
         if (i == 16) chk("ovf_full_16", 32'(bus.full), 32'd1);
      end
      chk("ovf_sticky", 32'(bus.overflow), 32'd1);
      chk("ovf_word_count", 32'(bus.word_count), 32'd16);
      for (int i = 1; i <= 16; i++) begin
         idle_step(1'b1);
         chk("ovf_pop_order", bus.dataout, 32'h100 + 32'(i));
      end
      chk("ovf_drained", 32'(bus.empty), 32'd1);

      // simultaneous push and pop, full and half-full, across pointer wrap
      do_restart();
      send(MY, 32'h1); send(MY, 32'h2);
      for (int i = 0; i < 16; i++) send(MY, 32'h200 + 32'(i));
      step(1'b1, MY, 32'h2FF, 1'b1, 1'b0);
      chk("sim_full_drop_ovf", 32'(bus.overflow), 32'd1);
      chk("sim_full_drop_pop", bus.dataout, 32'h200);
      chk("sim_full_drop_cnt", 32'(bus.full), 32'd0);
      for (int i = 0; i < 7; i++) idle_step(1'b1);
      for (int i = 0; i < 12; i++) step(1'b1, MY, 32'h300 + 32'(i), 1'b1, 1'b0);
      chk("sim_half_wc", 32'(bus.word_count), 32'd28);
      for (int i = 0; i < 9; i++) idle_step(1'b1);
      chk("sim_last_word", bus.dataout, 32'h30B);
      chk("sim_drained", 32'(bus.empty), 32'd1);

      // early terminator, later flits ignored, then restart and stream 2
      do_restart();
      send(MY, TERM);
      chk("early_done", 32'(bus.done), 32'd1);
      chk("early_kw", bus.keywordnumber, 32'd0);
      send(MY, 32'h55); send(MY, 32'h66);
      chk("early_ignored_kw", bus.keywordnumber, 32'd0);
      chk("early_ignored_empty", 32'(bus.empty), 32'd1);
      do_restart();
      stream2();
      chk("restart_kw", bus.keywordnumber, 32'h3);
      chk("restart_tf", bus.textfilenumber, 32'h5);

      // randomized traffic against the model
      do_restart();
      for (int n = 0; n < 3000; n++) begin
         logic        en, rn, rs;
         logic [3:0]  tag;
         logic [31:0] data;
         int          r;
         en = ($urandom_range(0, 3) != 0);
         r  = $urandom_range(0, 9);
         tag = (r < 6) ? MY : (r < 8) ? SEQ : 4'($urandom_range(0, 15));
         data = ($urandom_range(0, 63) == 0) ? TERM : $urandom;
         rn = ($urandom_range(0, 2) == 0);
         rs = m_done ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 499) == 0);
         step(en, tag, data, rn, rs);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
